// File: rtl/reset_req_gen.sv
// Watchdog / software reset-request generator: emits a fixed-width, flop-driven
// reset-request pulse followed by a forced-low hold-off window.
module reset_req_gen #(
    parameter int TIMEOUT_W   = 16,
    parameter int PULSE_LEN   = 4,
    parameter int HOLDOFF_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 kick,
    input  logic                 sw_req,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 reset_req,
    output logic                 busy,
    output logic [1:0]           cause,
    output logic [7:0]           fire_count
);

    localparam int PH_MAX = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PULSE,
        ST_HOLDOFF
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMEOUT_W-1:0] r_count;
    logic [TIMEOUT_W-1:0] w_count_next;
    logic [PH_W-1:0]      r_phase;
    logic [PH_W-1:0]      w_phase_next;
    logic [1:0]           r_cause;
    logic [1:0]           w_cause_next;
    logic [7:0]           r_fire_count;
    logic                 r_reset_req;
    logic                 r_busy;
    logic                 w_expired;
    logic                 w_enter_pulse;

    // A zero timeout disables the watchdog, so an empty counter only counts with a live period.
    assign w_expired     = (r_count == '0) && (timeout != '0);
    assign w_enter_pulse = (w_state_next == ST_PULSE) && (r_state != ST_PULSE);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_phase_next = r_phase;
        w_cause_next = r_cause;
        unique case (r_state)
            ST_IDLE: begin
                if (sw_req) begin
                    w_state_next = ST_PULSE;
                    w_phase_next = '0;
                    w_cause_next = 2'b01;
                end else if (enable) begin
                    w_state_next = ST_ARMED;
                    w_count_next = timeout;
                end
            end
            ST_ARMED: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (sw_req) begin
                    w_state_next = ST_PULSE;
                    w_phase_next = '0;
                    w_cause_next = w_expired ? 2'b11 : 2'b01;
                end else if (kick) begin
                    w_count_next = timeout;
                end else if (w_expired) begin
                    w_state_next = ST_PULSE;
                    w_phase_next = '0;
                    w_cause_next = 2'b10;
                end else if (r_count != '0) begin
                    w_count_next = r_count - TIMEOUT_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_phase == PH_W'(PULSE_LEN - 1)) begin
                    w_state_next = ST_HOLDOFF;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (r_phase == PH_W'(HOLDOFF_LEN - 1)) begin
                    w_phase_next = '0;
                    if (enable) begin
                        w_state_next = ST_ARMED;
                        w_count_next = timeout;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_phase      <= '0;
            r_cause      <= 2'b00;
            r_fire_count <= 8'd0;
            r_reset_req  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_phase     <= w_phase_next;
            r_cause     <= w_cause_next;
            r_reset_req <= (w_state_next == ST_PULSE);
            r_busy      <= (w_state_next == ST_PULSE) || (w_state_next == ST_HOLDOFF);
            if (w_enter_pulse && (r_fire_count != 8'hFF)) begin
                r_fire_count <= r_fire_count + 8'd1;
            end
        end
    end

    assign reset_req  = r_reset_req;
    assign busy       = r_busy;
    assign cause      = r_cause;
    assign fire_count = r_fire_count;

endmodule

// File: tb/tb_reset_req_gen.sv
// Directed self-checking bench for reset_req_gen with default parameters
// (TIMEOUT_W=16, PULSE_LEN=4, HOLDOFF_LEN=8).
module tb_reset_req_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        kick;
    logic        sw_req;
    logic [15:0] timeout;
    logic        reset_req;
    logic        busy;
    logic [1:0]  cause;
    logic [7:0]  fire_count;

    int n_cmp;
    int n_err;

    reset_req_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .kick       (kick),
        .sw_req     (sw_req),
        .timeout    (timeout),
        .reset_req  (reset_req),
        .busy       (busy),
        .cause      (cause),
        .fire_count (fire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        kick    = 1'b0;
        sw_req  = 1'b0;
        timeout = 16'd5;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Counts edges until reset_req is seen high; returns limit+1 on timeout.
    task automatic wait_rise(input int limit, output int n);
        n = 0;
        while (!reset_req && n <= limit) begin
            tick();
            n++;
        end
    endtask

    int n;
    int seen;
    int hi;
    int bz;
    logic r_samp [0:18];

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state and watchdog expiry
        do_reset();
        check("rst_reset_req", int'(reset_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cause", int'(cause), 0);
        check("rst_fire_count", int'(fire_count), 0);
        enable  = 1'b1;
        timeout = 16'd5;
        tick();                               // arming edge
        wait_rise(50, n);
        check("wd_latency", n, 6);
        check("wd_cause", int'(cause), 2);
        check("wd_fire_count", int'(fire_count), 1);
        hi = 0;
        bz = 0;
        for (int s = 0; s < 19; s++) begin
            r_samp[s] = reset_req;
            if (s < 17) begin
                hi += int'(reset_req);
                bz += int'(busy);
            end
            if (s < 18) tick();
        end
        check("wd_pulse_len", hi, 4);
        check("wd_busy_len", bz, 12);
        check("wd_low_before_rearm", int'(r_samp[17]), 0);
        check("wd_rearm_pulse", int'(r_samp[18]), 1);
        check("wd_rearm_fire_count", int'(fire_count), 2);

        // Periodic kicks keep the watchdog quiet, including a kick on the empty-counter cycle
        do_reset();
        enable  = 1'b1;
        timeout = 16'd5;
        tick();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            kick = (i % 4 == 3);
            tick();
            seen |= int'(reset_req);
        end
        kick = 1'b0;
        check("kick_every4_no_pulse", seen, 0);
        for (int r = 0; r < 3; r++) begin
            repeat (5) begin
                tick();
                seen |= int'(reset_req);
            end
            kick = 1'b1;
            tick();
            kick = 1'b0;
            seen |= int'(reset_req);
        end
        check("kick_at_zero_no_pulse", seen, 0);
        wait_rise(20, n);
        check("after_last_kick_latency", n, 6);
        check("after_last_kick_cause", int'(cause), 2);

        // Software request from IDLE; a second request in HOLDOFF is dropped
        do_reset();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        check("sw_pulse", int'(reset_req), 1);
        check("sw_busy", int'(busy), 1);
        check("sw_cause", int'(cause), 1);
        check("sw_fire_count", int'(fire_count), 1);
        repeat (5) tick();
        check("sw_in_holdoff", int'(busy && !reset_req), 1);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        seen = int'(reset_req);
        repeat (20) begin
            tick();
            seen |= int'(reset_req);
        end
        check("sw_holdoff_dropped", seen, 0);
        check("sw_holdoff_fire_count", int'(fire_count), 1);

        // timeout=0 never fires; software still can
        do_reset();
        enable  = 1'b1;
        timeout = 16'd0;
        seen = 0;
        repeat (1000) begin
            tick();
            seen |= int'(reset_req);
        end
        check("t0_no_pulse", seen, 0);
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        check("t0_sw_pulse", int'(reset_req), 1);
        check("t0_sw_cause", int'(cause), 1);

        // sw_req coincident with expiry, then reset mid-pulse
        do_reset();
        enable  = 1'b1;
        timeout = 16'd3;
        tick();
        repeat (3) tick();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        check("both_pulse", int'(reset_req), 1);
        check("both_cause", int'(cause), 3);
        check("both_fire_count", int'(fire_count), 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_reset_req", int'(reset_req), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_cause", int'(cause), 0);
        check("midrst_fire_count", int'(fire_count), 0);
        rst_n = 1'b1;

        // Saturation of the event counter
        do_reset();
        for (int e = 1; e <= 300; e++) begin
            sw_req = 1'b1;
            tick();
            sw_req = 1'b0;
            repeat (12) tick();
            if (e == 10)  check("sat_fire_10", int'(fire_count), 10);
            if (e == 255) check("sat_fire_255", int'(fire_count), 255);
        end
        check("sat_fire_300", int'(fire_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
